// File: rtl/qpu_trigger_evq_pkg.sv
// qpu_trigger_evq_pkg: shared widths, entry format and sequencer states for the trigger event queue
package qpu_trigger_evq_pkg;
    localparam int TIME_W    = 16;
    localparam int EVENT_NUM = 4;
    localparam int EVENT_WW  = 8;
    localparam int PAYLOAD_W = (TIME_W > EVENT_NUM + EVENT_WW) ? TIME_W : EVENT_NUM + EVENT_WW;
    localparam int ENTRY_W   = PAYLOAD_W + 1;
    localparam logic QPU_TRIG_TAG_TIME  = 1'b0;
    localparam logic QPU_TRIG_TAG_EVENT = 1'b1;
    typedef enum logic {QPU_TRIG_ST_IDLE = 1'b0, QPU_TRIG_ST_WAIT = 1'b1} trig_state_e;
    typedef struct packed {
        logic                 tag;
        logic [PAYLOAD_W-1:0] payload;
    } trig_entry_t;
    function automatic trig_entry_t mk_time(input logic [TIME_W-1:0] t);
        return '{tag: QPU_TRIG_TAG_TIME, payload: PAYLOAD_W'(t)};
    endfunction
    function automatic trig_entry_t mk_event(input logic [EVENT_NUM-1:0] m, input logic [EVENT_WW-1:0] d);
        return '{tag: QPU_TRIG_TAG_EVENT, payload: PAYLOAD_W'({m, d})};
    endfunction
endpackage

// File: rtl/qpu_trigger_fifo.sv
// qpu_trigger_fifo: ordered entry FIFO with a TIME and an EVENT write port and one read port
//   clk, rst_n (sync, active low), flush: clear pointers and count
//   wr_time/din_time, wr_event/din_event: writes; TIME lands ahead of EVENT when both fire
//   rd: pop head; count/empty/head: registered occupancy and current head entry
module qpu_trigger_fifo
    import qpu_trigger_evq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wr_time,
    input  trig_entry_t din_time,
    input  logic        wr_event,
    input  trig_entry_t din_event,
    input  logic        rd,
    output logic [AW:0] count,
    output logic        empty,
    output trig_entry_t head
);
    trig_entry_t    mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic           live;
    assign live  = rst_n & ~flush;
    assign empty = count == '0;
    assign head  = mem[rptr];
    always_ff @(posedge clk) begin
        if (live && wr_time) mem[wptr] <= din_time;
        if (live && wr_event) mem[wr_time ? wptr + AW'(1) : wptr] <= din_event;
    end
    always_ff @(posedge clk) begin
        if (!live) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_time) + AW'(wr_event);
            rptr  <= rptr + AW'(rd);
            count <= count + (AW+1)'(wr_time) + (AW+1)'(wr_event) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/qpu_trigger_evq.sv
// qpu_trigger_evq: replays queued wait-time and event entries as one-cycle trigger strobes
//   clk, rst_n (sync, active low); trigger_i_flush clears queue and sequencer
//   tiq_wbck_*: time entries; evq_wbck_* with erf_oprand/erf_data: event entries
//   trigger_o_valid/data: per-channel strobe and payload; trigger_o_busy: queue or wait active
//   trigger_o_stamp: fire timestamp, present only when QPU_TRIGGER_STAMP_EN is defined
module qpu_trigger_evq
    import qpu_trigger_evq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tiq_wbck_ena,
    output logic                 tiq_wbck_ready,
    input  logic [TIME_W-1:0]    tiq_wbck_data,
    input  logic                 evq_wbck_ena,
    output logic                 evq_wbck_ready,
    input  logic [EVENT_NUM-1:0] erf_oprand,
    input  logic [EVENT_WW-1:0]  erf_data,
    input  logic                 trigger_i_flush,
    output logic [EVENT_NUM-1:0] trigger_o_valid,
    output logic [EVENT_WW-1:0]  trigger_o_data,
    output logic                 trigger_o_busy
`ifdef QPU_TRIGGER_STAMP_EN
    ,output logic [TIME_W-1:0]   trigger_o_stamp
`endif
);
    trig_state_e          state;
    logic [TIME_W-1:0]    cnt;
    logic [AW:0]          count;
    logic                 empty, ready, pop, is_event;
    trig_entry_t          head;
    logic [TIME_W-1:0]    head_time;
    logic [EVENT_NUM-1:0] head_mask;
    logic [EVENT_WW-1:0]  head_data;
    // Room for two entries keeps a same-cycle TIME+EVENT push safe without looking at ena.
    assign ready          = count <= (AW+1)'(DEPTH - 2);
    assign tiq_wbck_ready = ready;
    assign evq_wbck_ready = ready;
    assign pop            = state == QPU_TRIG_ST_IDLE && !empty;
    assign is_event       = head.tag == QPU_TRIG_TAG_EVENT;
    assign head_time      = head.payload[TIME_W-1:0];
    assign head_mask      = head.payload[EVENT_WW +: EVENT_NUM];
    assign head_data      = head.payload[EVENT_WW-1:0];
    assign trigger_o_busy = count != '0 || state == QPU_TRIG_ST_WAIT;
    qpu_trigger_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (trigger_i_flush),
        .wr_time   (tiq_wbck_ena & ready),
        .din_time  (mk_time(tiq_wbck_data)),
        .wr_event  (evq_wbck_ena & ready),
        .din_event (mk_event(erf_oprand, erf_data)),
        .rd        (pop),
        .count     (count),
        .empty     (empty),
        .head      (head)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= QPU_TRIG_ST_IDLE;
            cnt             <= '0;
            trigger_o_valid <= '0;
            trigger_o_data  <= '0;
        end else if (trigger_i_flush) begin
            state           <= QPU_TRIG_ST_IDLE;
            cnt             <= '0;
            trigger_o_valid <= '0;
        end else begin
            trigger_o_valid <= (pop && is_event) ? head_mask : '0;
            if (pop && is_event && head_mask != '0) trigger_o_data <= head_data;
            if (state == QPU_TRIG_ST_WAIT) begin
                cnt <= cnt - TIME_W'(1);
                if (cnt == TIME_W'(1)) state <= QPU_TRIG_ST_IDLE;
            end else if (pop && !is_event && head_time != '0) begin
                cnt   <= head_time;
                state <= QPU_TRIG_ST_WAIT;
            end
        end
    end
`ifdef QPU_TRIGGER_STAMP_EN
    logic [TIME_W-1:0] stamp_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stamp_cnt       <= '0;
            trigger_o_stamp <= '0;
        end else if (trigger_i_flush) begin
            stamp_cnt       <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + TIME_W'(1);
            if (pop && is_event) trigger_o_stamp <= stamp_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_qpu_trigger_evq.sv
// tb_qpu_trigger_evq: directed scoreboard bench for qpu_trigger_evq
module tb_qpu_trigger_evq;
    import qpu_trigger_evq_pkg::*;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 tiq_wbck_ena, tiq_wbck_ready;
    logic [TIME_W-1:0]    tiq_wbck_data;
    logic                 evq_wbck_ena, evq_wbck_ready;
    logic [EVENT_NUM-1:0] erf_oprand;
    logic [EVENT_WW-1:0]  erf_data;
    logic                 trigger_i_flush;
    logic [EVENT_NUM-1:0] trigger_o_valid;
    logic [EVENT_WW-1:0]  trigger_o_data;
    logic                 trigger_o_busy;
`ifdef QPU_TRIGGER_STAMP_EN
    logic [TIME_W-1:0]    trigger_o_stamp;
`endif
    typedef struct {
        logic [EVENT_NUM-1:0] v;
        logic [EVENT_WW-1:0]  d;
        int                   cyc;
        int                   stamp;
    } exp_t;
    exp_t sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   c, s0;
    qpu_trigger_evq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tiq_wbck_ena    (tiq_wbck_ena),
        .tiq_wbck_ready  (tiq_wbck_ready),
        .tiq_wbck_data   (tiq_wbck_data),
        .evq_wbck_ena    (evq_wbck_ena),
        .evq_wbck_ready  (evq_wbck_ready),
        .erf_oprand      (erf_oprand),
        .erf_data        (erf_data),
        .trigger_i_flush (trigger_i_flush),
        .trigger_o_valid (trigger_o_valid),
        .trigger_o_data  (trigger_o_data),
        .trigger_o_busy  (trigger_o_busy)
`ifdef QPU_TRIGGER_STAMP_EN
        ,.trigger_o_stamp (trigger_o_stamp)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Every strobe must match the oldest pending expectation in mask, payload and cycle.
    always @(negedge clk) begin
        if (trigger_o_valid !== '0) begin
            exp_t e;
            strobes++;
            chk("unexpected_strobe", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("strobe_mask", 32'(trigger_o_valid), 32'(e.v));
                chk("strobe_data", 32'(trigger_o_data), 32'(e.d));
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
`ifdef QPU_TRIGGER_STAMP_EN
                if (e.stamp >= 0) chk("strobe_stamp", 32'(trigger_o_stamp), 32'(e.stamp));
`endif
            end
        end
    end
    initial begin
        rst_n = 1'b0;
        tiq_wbck_ena = 1'b0;
        tiq_wbck_data = '0;
        evq_wbck_ena = 1'b0;
        erf_oprand = '0;
        erf_data = '0;
        trigger_i_flush = 1'b0;
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_tiq_ready", 32'(tiq_wbck_ready), 32'd1);
        chk("rst_evq_ready", 32'(evq_wbck_ready), 32'd1);
        chk("rst_valid", 32'(trigger_o_valid), 32'd0);
        chk("rst_busy", 32'(trigger_o_busy), 32'd0);
        chk("rst_data", 32'(trigger_o_data), 32'd0);
        rst_n = 1'b1;
        // Single event: strobe two cycles after acceptance
        @(negedge clk);
        c = cyc;
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'b0010;
        erf_data = 8'h3C;
        sb.push_back('{4'b0010, 8'h3C, c + 2, -1});
        @(negedge clk);
        evq_wbck_ena = 1'b0;
        repeat (4) @(negedge clk);
        chk("single_busy_after", 32'(trigger_o_busy), 32'd0);
        chk("single_data_hold", 32'(trigger_o_data), 32'h3C);
        // Wait T=5 then event: pops at 1 and 7, strobe at 8
        @(negedge clk);
        c = cyc;
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = 16'd5;
        @(negedge clk);
        tiq_wbck_ena = 1'b0;
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'b0001;
        erf_data = 8'hA5;
        sb.push_back('{4'b0001, 8'hA5, c + 8, -1});
        @(negedge clk);
        evq_wbck_ena = 1'b0;
        chk("wait_busy", 32'(trigger_o_busy), 32'd1);
        repeat (10) @(negedge clk);
        // Same-cycle TIME(0) + EVENT: count 2 -> 1 -> 0, strobe at cycle 3
        c = cyc;
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = 16'd0;
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'b1000;
        erf_data = 8'h5A;
        sb.push_back('{4'b1000, 8'h5A, c + 3, -1});
        @(negedge clk);
        tiq_wbck_ena = 1'b0;
        evq_wbck_ena = 1'b0;
        chk("dual_count_c1", 32'(dut.count), 32'd2);
        @(negedge clk);
        chk("dual_count_c2", 32'(dut.count), 32'd1);
        @(negedge clk);
        chk("dual_count_c3", 32'(dut.count), 32'd0);
        repeat (3) @(negedge clk);
        // Backpressure during a T=100 wait
        c = cyc;
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = 16'd100;
        @(negedge clk);
        tiq_wbck_ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_evq_ready", 32'(evq_wbck_ready), 32'(i < 7));
            chk("bp_tiq_ready", 32'(tiq_wbck_ready), 32'(i < 7));
            evq_wbck_ena = 1'b1;
            tiq_wbck_ena = (i == 7);
            tiq_wbck_data = 16'd3;
            erf_oprand = 4'(1 << (i % 4));
            erf_data = 8'(8'h10 + i);
            if (i < 7) sb.push_back('{4'(1 << (i % 4)), 8'(8'h10 + i), c + 103 + i, -1});
        end
        @(negedge clk);
        evq_wbck_ena = 1'b0;
        tiq_wbck_ena = 1'b0;
        chk("bp_count_full7", 32'(dut.count), 32'd7);
        repeat (120) @(negedge clk);
        chk("bp_drained", 32'(trigger_o_busy), 32'd0);
        // Flush mid-WAIT with three events queued
        c = cyc;
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = 16'd50;
        @(negedge clk);
        tiq_wbck_ena = 1'b0;
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'hF;
        erf_data = 8'hEE;
        repeat (3) @(negedge clk);
        evq_wbck_ena = 1'b0;
        repeat (7) @(negedge clk);
        chk("flush_pre_busy", 32'(trigger_o_busy), 32'd1);
        trigger_i_flush = 1'b1;
        @(negedge clk);
        trigger_i_flush = 1'b0;
        chk("flush_busy", 32'(trigger_o_busy), 32'd0);
        chk("flush_count", 32'(dut.count), 32'd0);
        chk("flush_valid", 32'(trigger_o_valid), 32'd0);
        s0 = strobes;
        repeat (41) @(negedge clk);
        chk("flush_no_strobe", 32'(strobes), 32'(s0));
`ifdef QPU_TRIGGER_STAMP_EN
        // Counter restarted at the flush; the pop lands when it reads 42
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'b0010;
        erf_data = 8'h42;
        sb.push_back('{4'b0010, 8'h42, cyc + 2, 42});
        @(negedge clk);
        evq_wbck_ena = 1'b0;
        repeat (5) @(negedge clk);
`endif
        // Reset mid-WAIT discards everything
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = 16'd20;
        evq_wbck_ena = 1'b1;
        erf_oprand = 4'b0001;
        erf_data = 8'h77;
        @(negedge clk);
        tiq_wbck_ena = 1'b0;
        evq_wbck_ena = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(trigger_o_busy), 32'd0);
        chk("midrst_data", 32'(trigger_o_data), 32'd0);
        s0 = strobes;
        repeat (30) @(negedge clk);
        chk("midrst_no_strobe", 32'(strobes), 32'(s0));
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
